// File: rtl/test_iterator.sv
// Sample-position iterator: accepts one triangle plus its snapped bounding box and
// emits every sample position inside the box, row-major, one beat per handshake.
module test_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tri_valid_i,
  output logic                            tri_ready_o,
  input  logic [VERTS*AXIS*SIGFIG-1:0]    tri_i,
  input  logic [COLORS*SIGFIG-1:0]        color_i,
  input  logic [4*SIGFIG-1:0]             box_i,
  input  logic [3:0]                      subsample_i,
  output logic                            samp_valid_o,
  input  logic                            samp_ready_i,
  output logic [VERTS*AXIS*SIGFIG-1:0]    tri_o,
  output logic [COLORS*SIGFIG-1:0]        color_o,
  output logic [2*SIGFIG-1:0]             sample_o,
  output logic                            last_o
);

  typedef enum logic {IDLE, WALK} state_t;

  state_t state;

  logic signed [SIGFIG-1:0] ll_x, ur_x, ur_y, x, y, step;
  logic signed [SIGFIG-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y, step_in;
  logic signed [SIGFIG:0]   x_ext, y_ext, step_ext, ur_x_ext, ur_y_ext, x_next, y_next;
  logic                     x_wrap, y_done;

  assign in_ll_x = box_i[SIGFIG-1:0];
  assign in_ll_y = box_i[2*SIGFIG-1:SIGFIG];
  assign in_ur_x = box_i[3*SIGFIG-1:2*SIGFIG];
  assign in_ur_y = box_i[4*SIGFIG-1:3*SIGFIG];

  always_comb begin
    case (subsample_i)
      4'b0100: step_in = SIGFIG'(1) << (RADIX - 1);
      4'b0010: step_in = SIGFIG'(1) << (RADIX - 2);
      4'b0001: step_in = SIGFIG'(1) << (RADIX - 3);
      default: step_in = SIGFIG'(1) << RADIX;
    endcase
  end

  // One extra bit so a box touching the positive maximum never wraps.
  assign x_ext    = {x[SIGFIG-1], x};
  assign y_ext    = {y[SIGFIG-1], y};
  assign ur_x_ext = {ur_x[SIGFIG-1], ur_x};
  assign ur_y_ext = {ur_y[SIGFIG-1], ur_y};
  assign step_ext = {1'b0, step};
  assign x_next   = x_ext + step_ext;
  assign y_next   = y_ext + step_ext;
  assign x_wrap   = x_next > ur_x_ext;
  assign y_done   = y_next > ur_y_ext;

  assign tri_ready_o = (state == IDLE);
  assign last_o      = (state == WALK) && x_wrap && y_done;
  assign sample_o    = {y, x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      samp_valid_o <= 1'b0;
      tri_o        <= '0;
      color_o      <= '0;
      ll_x         <= '0;
      ur_x         <= '0;
      ur_y         <= '0;
      step         <= '0;
      x            <= '0;
      y            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tri_valid_i) begin
            tri_o   <= tri_i;
            color_o <= color_i;
            ll_x    <= in_ll_x;
            ur_x    <= in_ur_x;
            ur_y    <= in_ur_y;
            step    <= step_in;
            if (!(in_ll_x > in_ur_x || in_ll_y > in_ur_y)) begin
              x            <= in_ll_x;
              y            <= in_ll_y;
              samp_valid_o <= 1'b1;
              state        <= WALK;
            end
          end
        end
        WALK: begin
          if (samp_valid_o && samp_ready_i) begin
            if (x_wrap && y_done) begin
              samp_valid_o <= 1'b0;
              state        <= IDLE;
            end else if (!x_wrap) begin
              x <= x_next[SIGFIG-1:0];
            end else begin
              x <= ll_x;
              y <= y_next[SIGFIG-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_iterator.sv
// Randomized bench for test_iterator: a queue-based model enumerates the expected
// sample positions of each accepted box and a negedge process compares every cycle.
module tb_test_iterator;

  localparam int SIGFIG = 24;
  localparam int TW = 3 * 3 * SIGFIG;
  localparam int CW = 3 * SIGFIG;

  typedef logic [2*SIGFIG-1:0] smp_t;
  typedef smp_t smp_q_t[$];

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tri_valid_i = 1'b0;
  logic            tri_ready_o;
  logic [TW-1:0]   tri_i = '0;
  logic [CW-1:0]   color_i = '0;
  logic [95:0]     box_i = '0;
  logic [3:0]      subsample_i = 4'b1000;
  logic            samp_valid_o;
  logic            samp_ready_i = 1'b1;
  logic [TW-1:0]   tri_o;
  logic [CW-1:0]   color_o;
  logic [47:0]     sample_o;
  logic            last_o;

  int tests = 0;
  int fails = 0;
  bit rdy_rand = 1'b0;

  smp_q_t        exp_q;
  logic [TW-1:0] exp_tri = '0;
  logic [CW-1:0] exp_col = '0;

  test_iterator #(.SIGFIG(24), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
    .clk(clk), .rst_n(rst_n), .tri_valid_i(tri_valid_i), .tri_ready_o(tri_ready_o),
    .tri_i(tri_i), .color_i(color_i), .box_i(box_i), .subsample_i(subsample_i),
    .samp_valid_o(samp_valid_o), .samp_ready_i(samp_ready_i), .tri_o(tri_o),
    .color_o(color_o), .sample_o(sample_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint step_of(input logic [3:0] sub);
    case (sub)
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  // Enumerate every grid position of the box, rows bottom to top, left to right.
  function automatic smp_q_t gen(input logic [95:0] box, input logic [3:0] sub);
    smp_q_t q;
    longint llx, lly, urx, ury, st;
    logic [23:0] xs, ys;
    llx = longint'($signed(box[23:0]));
    lly = longint'($signed(box[47:24]));
    urx = longint'($signed(box[71:48]));
    ury = longint'($signed(box[95:72]));
    st  = step_of(sub);
    for (longint yy = lly; yy <= ury; yy += st)
      for (longint xx = llx; xx <= urx; xx += st) begin
        xs = 24'(xx);
        ys = 24'(yy);
        q.push_back({ys, xs});
      end
    return q;
  endfunction

  function automatic logic [95:0] mkbox(input int llx, input int lly, input int urx, input int ury);
    return {24'(ury), 24'(urx), 24'(lly), 24'(llx)};
  endfunction

  always @(posedge clk) begin
    #1;
    if (rdy_rand) samp_ready_i = ($urandom_range(0, 3) != 0);
  end

  // Per-cycle compare, then predict what the coming rising edge does to the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_valid", 64'(samp_valid_o), 64'd0);
    end else begin
      chk("valid", 64'(samp_valid_o), 64'(exp_q.size() > 0));
      chk("ready", 64'(tri_ready_o), 64'(exp_q.size() == 0));
      if (exp_q.size() > 0) begin
        chk("sample", 64'(sample_o), 64'(exp_q[0]));
        chk("last", 64'(last_o), 64'(exp_q.size() == 1));
        chk("tri", 64'(tri_o == exp_tri), 64'd1);
        chk("color", 64'(color_o == exp_col), 64'd1);
        if (samp_ready_i) void'(exp_q.pop_front());
      end else begin
        chk("last_idle", 64'(last_o), 64'd0);
        if (tri_valid_i) begin
          exp_q   = gen(box_i, subsample_i);
          exp_tri = tri_i;
          exp_col = color_i;
        end
      end
    end
  end

  task automatic send(input logic [95:0] box, input logic [3:0] sub);
    bit ok = 1'b0;
    @(posedge clk); #1;
    tri_valid_i = 1'b1;
    box_i       = box;
    subsample_i = sub;
    for (int w = 0; w < 9; w++) tri_i[w*24 +: 24] = 24'($urandom);
    for (int c = 0; c < 3; c++) color_i[c*24 +: 24] = 24'($urandom);
    for (int i = 0; i < 400; i++) begin
      if (tri_ready_o) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    tri_valid_i = 1'b0;
    box_i       = {$urandom, $urandom, $urandom};
    tri_i       = ~tri_i;
    color_i     = ~color_i;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (tri_ready_o && !samp_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    smp_q_t q;
    int st, llx, lly, w, h;
    logic [3:0] sub;

    q = gen(mkbox(0, 0, 1024, 1024), 4'b1000);
    chk("model_cnt1", 64'(q.size()), 64'd4);
    q = gen(mkbox(0, 0, 1024, 1024), 4'b0100);
    chk("model_cnt2", 64'(q.size()), 64'd9);
    chk("model_s2_1", 64'(q[1]), {16'd0, 24'd0, 24'd512});
    q = gen(mkbox(2048, 3072, 2048, 3072), 4'b0010);
    chk("model_cnt3", 64'(q.size()), 64'd1);
    q = gen(mkbox(2048, 0, 1024, 0), 4'b1000);
    chk("model_cnt5", 64'(q.size()), 64'd0);

    #12;
    chk("rst_ready", 64'(tri_ready_o), 64'd1);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_sample", 64'(sample_o), 64'd0);
    chk("rst_tri", 64'(tri_o == '0), 64'd1);
    chk("rst_color", 64'(color_o == '0), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: 2x2 box, full step
    send(mkbox(0, 0, 1024, 1024), 4'b1000);
    chk("s1_first", 64'(sample_o), 64'd0);
    wait_idle();
    // 2: same box, half step
    send(mkbox(0, 0, 1024, 1024), 4'b0100);
    wait_idle();
    // 3: degenerate box
    send(mkbox(2048, 3072, 2048, 3072), 4'b0001);
    chk("s3_sample", 64'(sample_o), {16'd0, 24'd3072, 24'd2048});
    chk("s3_last", 64'(last_o), 64'd1);
    wait_idle();
    // 4: backpressure on the first beat
    send(mkbox(-1024, 0, 0, 0), 4'b1000);
    samp_ready_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("s4_hold", 64'(sample_o), {16'd0, 24'd0, 24'hFFFC00});
    chk("s4_hold_v", 64'(samp_valid_o), 64'd1);
    samp_ready_i = 1'b1;
    wait_idle();
    // 5: inverted box is dropped, next triangle runs normally
    send(mkbox(2048, 0, 1024, 0), 4'b1000);
    chk("s5_drop", 64'(samp_valid_o), 64'd0);
    send(mkbox(0, 0, 1024, 0), 4'b0100);
    wait_idle();
    // box touching the positive maximum must stop after two columns
    send(mkbox(8386560, 8387584, 8387584, 8387584), 4'b1000);
    wait_idle();
    // non-one-hot subsample behaves as full step
    send(mkbox(0, 0, 2048, 0), 4'b0110);
    wait_idle();
    // 6: reset during the third beat of the half-step walk
    send(mkbox(0, 0, 1024, 1024), 4'b0100);
    repeat (2) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    chk("s6_async_valid", 64'(samp_valid_o), 64'd0);
    chk("s6_ready", 64'(tri_ready_o), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send(mkbox(3072, -2048, 4096, -1024), 4'b1000);
    chk("s6_fresh", 64'(sample_o), {16'd0, 24'hFFF800, 24'd3072});
    wait_idle();

    rdy_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: sub = 4'b1000;
        1: sub = 4'b0100;
        2: sub = 4'b0010;
        3: sub = 4'b0001;
        default: sub = 4'($urandom);
      endcase
      st  = int'(step_of(sub));
      llx = st * ($urandom_range(0, 16) - 8);
      lly = st * ($urandom_range(0, 16) - 8);
      w   = st * $urandom_range(0, 3);
      h   = st * $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) w = -st;
      send(mkbox(llx, lly, llx + w, lly + h), sub);
    end
    wait_idle();
    rdy_rand = 1'b0;
    samp_ready_i = 1'b1;
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/test_iterator.md
Name: test_iterator

Overview:
- Rasterizer stage between the bounding-box stage and the sample-hash/sample-test stages.
- Accepts one triangle with its grid-snapped bounding box and subsample mode.
- Walks every sample position inside the box in row-major order and emits one (triangle, colour, sample position) beat per cycle.
- Uses valid/ready handshakes on both the input and output sides.

Parameters:
SIGFIG, 24, bits per coordinate/colour word (signed two's complement for coordinates)
RADIX, 10, fraction bits; 1.0 = 1<<RADIX
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, colour channels

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tri_valid_i  in  1  input triangle valid
tri_ready_o  out  1  stage can accept a triangle
tri_i  in  VERTS*AXIS*SIGFIG  triangle vertices
color_i  in  COLORS*SIGFIG  triangle colour
box_i  in  4*SIGFIG  {UR.y, UR.x, LL.y, LL.x}, snapped to the sample grid
subsample_i  in  4  one-hot step: 1000=1.0, 0100=0.5, 0010=0.25, 0001=0.125
samp_valid_o  out  1  output beat valid
samp_ready_i  in  1  downstream accepts beat
tri_o  out  VERTS*AXIS*SIGFIG  latched triangle
color_o  out  COLORS*SIGFIG  latched colour
sample_o  out  2*SIGFIG  {y, x} current sample position
last_o  out  1  final sample of the current triangle

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; samp_valid_o=0; last_o=0; tri_o, color_o, sample_o=0. tri_ready_o is decoded from state, so it is 1 after reset.
- FSM states: IDLE, WALK.
- IDLE:
  - tri_ready_o=1.
  - On tri_valid_i: latch tri, colour and box; step = 1<<(RADIX-k) for one-hot bit k (k=0 for 1000 … 3 for 0001).
  - Box check, signed comparisons:
    - If LL.x>UR.x or LL.y>UR.y: triangle is dropped, no beat is emitted, stay in IDLE.
    - Otherwise: sample_o={LL.y,LL.x}, samp_valid_o=1, go to WALK.
  - Latency: first sample beat is visible the cycle after the input handshake.
- WALK:
  - tri_ready_o=0.
  - Advance only on samp_valid_o && samp_ready_i. When ready is low, all outputs hold stable; no skipped or duplicated samples.
  - Next position:
    - If x+step <= UR.x: x += step.
    - Else: x = LL.x, y += step.
  - last_o=1 exactly when x+step > UR.x and y+step > UR.y, combinational on current registered position.
  - When the last beat is accepted: samp_valid_o=0, go to IDLE.
- Throughput: one sample per cycle under no backpressure; exactly one idle bubble between triangles (the IDLE accept cycle).
- Arithmetic: x+step and y+step are computed in SIGFIG+1 signed bits, so a box touching the positive maximum terminates correctly and never wraps.
- Invalid or non-one-hot subsample_i is treated as 1000.
- Degenerate box (LL==UR): one beat, with last_o=1.
- Reset mid-WALK: samp_valid_o drops immediately and asynchronously; the in-flight triangle is discarded; IDLE on the first clock after deassert.
- tri_i, color_i and box_i are sampled only at the accept handshake; changes while in WALK have no effect.
- Sample count for a valid box = ((UR.x-LL.x)/step+1) * ((UR.y-LL.y)/step+1).

Test Plan:
1. Box LL=(0,0), UR=(1024,1024), subsample 1000, ready tied high -> 4 beats (0,0),(1024,0),(0,1024),(1024,1024) on consecutive cycles, last_o on the 4th only, tri_ready_o high the cycle after.
2. Same box, subsample 0100 -> 9 beats stepping 512: x sequence 0,512,1024 per row, y rows 0,512,1024; last at (1024,1024).
3. LL=UR=(2048,3072) -> exactly one beat (2048,3072) with last_o=1.
4. Box LL=(-1024,0), UR=(0,0), subsample 1000, samp_ready_i low for 3 cycles after the first beat -> (-1024,0) held for 4 cycles, then (0,0) with last; no duplicate or skipped beats.
5. Invalid box LL.x=2048, UR.x=1024 -> zero beats; tri_ready_o high on the next cycle; a following valid triangle is processed normally.
6. Assert rst_n low during the 3rd beat of scenario 2 -> samp_valid_o=0 immediately. After release, tri_ready_o=1; a new triangle starts at its own LL with no stale position.
